change_dispenser_seq: RTL and testbench

Sequential, parametrised change maker for the shape-coin vending datapath. It holds an internal inventory of pentagon, triangle and circle coins, and accepts one transaction at a time (Cost, Paid). It first plans a greedy change set on shadow counts, then commits only if the plan fully succeeds. It then emits coins one per accepted handshake, decrementing the inventory as each coin is taken.

---
 rtl/change_dispenser_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_change_dispenser_seq.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser_seq.sv
// Greedy change maker for shape coins: plans on shadow counts,
// then dispenses one coin per valid/ready handshake.
module change_dispenser_seq #(
  parameter int VALUE_W  = 4,
  parameter int CNT_W    = 2,
  parameter int PENT_VAL = 5,
  parameter int TRI_VAL  = 3,
  parameter int CIRC_VAL = 1
) (
  input  logic               clock,
  input  logic               reset_L,
  input  logic               restock,
  input  logic [CNT_W-1:0]   restock_pent,
  input  logic [CNT_W-1:0]   restock_tri,
  input  logic [CNT_W-1:0]   restock_circ,
  input  logic               start,
  input  logic [VALUE_W-1:0] cost,
  input  logic [VALUE_W-1:0] paid,
  output logic               coin_valid,
  input  logic               coin_ready,
  output logic [2:0]         coin,
  output logic [VALUE_W-1:0] remaining,
  output logic               busy,
  output logic               done,
  output logic               exact_amount,
  output logic               not_enough_change,
  output logic               cough_up_more,
  output logic [CNT_W-1:0]   pent_cnt,
  output logic [CNT_W-1:0]   tri_cnt,
  output logic [CNT_W-1:0]   circ_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAN,
    S_DISP,
    S_DONE
  } state_e;

  localparam logic [VALUE_W-1:0] PENT_V = VALUE_W'(PENT_VAL);
  localparam logic [VALUE_W-1:0] TRI_V  = VALUE_W'(TRI_VAL);
  localparam logic [VALUE_W-1:0] CIRC_V = VALUE_W'(CIRC_VAL);

  state_e             state_q, state_d;
  logic [VALUE_W:0]   chg_q, chg_d;
  logic [VALUE_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]   sp_q, sp_d;
  logic [CNT_W-1:0]   st_q, st_d;
  logic [CNT_W-1:0]   sc_q, sc_d;
  logic [CNT_W-1:0]   p_q, p_d;
  logic [CNT_W-1:0]   t_q, t_d;
  logic [CNT_W-1:0]   c_q, c_d;
  logic               exact_q, exact_d;
  logic               nec_q, nec_d;
  logic               cum_q, cum_d;

  logic [VALUE_W:0]   chg_new;
  logic [2:0]         plan_sel;
  logic [2:0]         disp_sel;
  logic [VALUE_W-1:0] plan_val;
  logic [VALUE_W-1:0] disp_val;
  logic [VALUE_W-1:0] disp_rem;

  // Largest coin not exceeding r that is still in stock.
  function automatic logic [2:0] pick(
    input logic [VALUE_W-1:0] r,
    input logic [CNT_W-1:0]   p,
    input logic [CNT_W-1:0]   t,
    input logic [CNT_W-1:0]   c
  );
    logic [2:0] s;
    s = 3'b000;
    if (r >= PENT_V && p != '0)
      s = 3'b100;
    else if (r >= TRI_V && t != '0)
      s = 3'b010;
    else if (r >= CIRC_V && c != '0)
      s = 3'b001;
    return s;
  endfunction

  function automatic logic [VALUE_W-1:0] value_of(
    input logic [2:0] s
  );
    logic [VALUE_W-1:0] v;
    v = '0;
    unique case (1'b1)
      s[2]:    v = PENT_V;
      s[1]:    v = TRI_V;
      s[0]:    v = CIRC_V;
      default: v = '0;
    endcase
    return v;
  endfunction

  assign chg_new  = {1'b0, paid} - {1'b0, cost};
  assign plan_sel = pick(rem_q, sp_q, st_q, sc_q);
  assign disp_sel = pick(rem_q, p_q, t_q, c_q);
  assign plan_val = value_of(plan_sel);
  assign disp_val = value_of(disp_sel);
  assign disp_rem = rem_q - disp_val;

  always_comb begin
    state_d    = state_q;
    chg_d      = chg_q;
    rem_d      = rem_q;
    sp_d       = sp_q;
    st_d       = st_q;
    sc_d       = sc_q;
    p_d        = p_q;
    t_d        = t_q;
    c_d        = c_q;
    exact_d    = exact_q;
    nec_d      = nec_q;
    cum_d      = cum_q;
    coin_valid = 1'b0;
    coin       = 3'b000;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          chg_d   = chg_new;
          rem_d   = chg_new[VALUE_W] ? '0
                                     : chg_new[VALUE_W-1:0];
          sp_d    = p_q;
          st_d    = t_q;
          sc_d    = c_q;
          exact_d = 1'b0;
          nec_d   = 1'b0;
          cum_d   = 1'b0;
          state_d = S_PLAN;
        end else if (restock) begin
          p_d = restock_pent;
          t_d = restock_tri;
          c_d = restock_circ;
        end
      end
      S_PLAN: begin
        if (chg_q[VALUE_W]) begin
          cum_d   = 1'b1;
          rem_d   = '0;
          state_d = S_DONE;
        end else if (chg_q == '0) begin
          exact_d = 1'b1;
          state_d = S_DONE;
        end else if (rem_q == '0) begin
          rem_d   = chg_q[VALUE_W-1:0];
          state_d = S_DISP;
        end else if (plan_sel != 3'b000) begin
          rem_d = rem_q - plan_val;
          sp_d  = sp_q - CNT_W'(plan_sel[2]);
          st_d  = st_q - CNT_W'(plan_sel[1]);
          sc_d  = sc_q - CNT_W'(plan_sel[0]);
        end else begin
          // Inventory is left alone; nothing was committed.
          nec_d   = 1'b1;
          rem_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DISP: begin
        coin_valid = 1'b1;
        coin       = disp_sel;
        if (disp_sel == 3'b000) begin
          state_d = S_DONE;
        end else if (coin_ready) begin
          p_d   = p_q - CNT_W'(disp_sel[2]);
          t_d   = t_q - CNT_W'(disp_sel[1]);
          c_d   = c_q - CNT_W'(disp_sel[0]);
          rem_d = disp_rem;
          if (disp_rem == '0)
            state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= S_IDLE;
      chg_q   <= '0;
      rem_q   <= '0;
      sp_q    <= '0;
      st_q    <= '0;
      sc_q    <= '0;
      p_q     <= '0;
      t_q     <= '0;
      c_q     <= '0;
      exact_q <= 1'b0;
      nec_q   <= 1'b0;
      cum_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chg_q   <= chg_d;
      rem_q   <= rem_d;
      sp_q    <= sp_d;
      st_q    <= st_d;
      sc_q    <= sc_d;
      p_q     <= p_d;
      t_q     <= t_d;
      c_q     <= c_d;
      exact_q <= exact_d;
      nec_q   <= nec_d;
      cum_q   <= cum_d;
    end
  end

  assign remaining         = rem_q;
  assign busy              = (state_q != S_IDLE);
  assign exact_amount      = exact_q;
  assign not_enough_change = nec_q;
  assign cough_up_more     = cum_q;
  assign pent_cnt          = p_q;
  assign tri_cnt           = t_q;
  assign circ_cnt          = c_q;

endmodule

// File: tb/tb_change_dispenser_seq.sv
// Scoreboard bench for change_dispenser_seq: a bench-side greedy
// model queues the expected coins, handshakes pop and compare them.
module tb_change_dispenser_seq;

  logic       clock;
  logic       reset_L;
  logic       restock;
  logic [1:0] restock_pent;
  logic [1:0] restock_tri;
  logic [1:0] restock_circ;
  logic       start;
  logic [3:0] cost;
  logic [3:0] paid;
  logic       coin_valid;
  logic       coin_ready;
  logic [2:0] coin;
  logic [3:0] remaining;
  logic       busy;
  logic       done;
  logic       exact_amount;
  logic       not_enough_change;
  logic       cough_up_more;
  logic [1:0] pent_cnt;
  logic [1:0] tri_cnt;
  logic [1:0] circ_cnt;

  int checks = 0;
  int passed = 0;

  logic [1:0] mp = 2'd0;
  logic [1:0] mt = 2'd0;
  logic [1:0] mc = 2'd0;
  logic [2:0] exp_q[$];

  change_dispenser_seq dut (
    .clock             (clock),
    .reset_L           (reset_L),
    .restock           (restock),
    .restock_pent      (restock_pent),
    .restock_tri       (restock_tri),
    .restock_circ      (restock_circ),
    .start             (start),
    .cost              (cost),
    .paid              (paid),
    .coin_valid        (coin_valid),
    .coin_ready        (coin_ready),
    .coin              (coin),
    .remaining         (remaining),
    .busy              (busy),
    .done              (done),
    .exact_amount      (exact_amount),
    .not_enough_change (not_enough_change),
    .cough_up_more     (cough_up_more),
    .pent_cnt          (pent_cnt),
    .tri_cnt           (tri_cnt),
    .circ_cnt          (circ_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // kind: 0 coins, 1 paid<cost, 2 exact, 3 not enough change
  task automatic model_txn(
    input  logic [3:0] c,
    input  logic [3:0] p,
    input  int         stall,
    output int         kind,
    output int         lat,
    output logic [3:0] chg
  );
    logic [4:0] d;
    int r, sp, st, sc, n;
    logic [2:0] picks[$];
    d    = {1'b0, p} - {1'b0, c};
    chg  = d[3:0];
    lat  = 1;
    kind = 0;
    if (d[4]) begin
      kind = 1;
      chg  = 4'd0;
    end else if (d == 5'd0) begin
      kind = 2;
    end else begin
      r  = int'(d);
      sp = int'(mp);
      st = int'(mt);
      sc = int'(mc);
      while (r > 0 && kind == 0) begin
        if (r >= 5 && sp > 0) begin
          picks.push_back(3'b100); r -= 5; sp--;
        end else if (r >= 3 && st > 0) begin
          picks.push_back(3'b010); r -= 3; st--;
        end else if (r >= 1 && sc > 0) begin
          picks.push_back(3'b001); r -= 1; sc--;
        end else begin
          kind = 3;
        end
      end
      n = picks.size();
      if (kind == 3) begin
        lat = n + 1;
      end else begin
        lat = n + 1 + n * (stall + 1);
        foreach (picks[i]) exp_q.push_back(picks[i]);
        mp = 2'(sp);
        mt = 2'(st);
        mc = 2'(sc);
      end
    end
  endtask

  task automatic do_restock(
    input logic [1:0] p,
    input logic [1:0] t,
    input logic [1:0] c
  );
    @(negedge clock);
    restock      = 1'b1;
    restock_pent = p;
    restock_tri  = t;
    restock_circ = c;
    mp = p;
    mt = t;
    mc = c;
    @(negedge clock);
    restock = 1'b0;
    checks++;
    if ({pent_cnt, tri_cnt, circ_cnt} !== {p, t, c})
      $display("FAIL restock_counts: got %b want %b",
               {pent_cnt, tri_cnt, circ_cnt}, {p, t, c});
    else passed++;
  endtask

  task automatic run_txn(
    input logic [3:0] c,
    input logic [3:0] p,
    input int         stall,
    input bit         also_restock
  );
    int kind, lat, waited, seen;
    logic [3:0] chg, exp_rem;
    logic [2:0] want;
    bit got_done;
    @(negedge clock);
    start = 1'b1;
    cost  = c;
    paid  = p;
    if (also_restock) begin
      restock      = 1'b1;
      restock_pent = 2'd3;
      restock_tri  = 2'd3;
      restock_circ = 2'd3;
    end
    model_txn(c, p, stall, kind, lat, chg);
    exp_rem = chg;
    @(negedge clock);
    start      = 1'b0;
    restock    = 1'b0;
    coin_ready = 1'b0;
    waited   = 0;
    seen     = 0;
    got_done = 1'b0;
    for (int i = 1; i <= 80 && !got_done; i++) begin
      @(negedge clock);
      if (done) begin
        got_done   = 1'b1;
        coin_ready = 1'b0;
        checks++;
        if (i != lat)
          $display("FAIL done_latency: got %0d want %0d", i, lat);
        else passed++;
        checks++;
        if ({cough_up_more, exact_amount, not_enough_change} !==
            {kind == 1, kind == 2, kind == 3})
          $display("FAIL status_flags: got %b want %b",
                   {cough_up_more, exact_amount, not_enough_change},
                   {kind == 1, kind == 2, kind == 3});
        else passed++;
        checks++;
        if ({pent_cnt, tri_cnt, circ_cnt} !== {mp, mt, mc})
          $display("FAIL final_counts: got %b want %b",
                   {pent_cnt, tri_cnt, circ_cnt}, {mp, mt, mc});
        else passed++;
        checks++;
        if (exp_q.size() != 0)
          $display("FAIL coins_missing: got %0d left want 0",
                   exp_q.size());
        else passed++;
        checks++;
        if (busy !== 1'b1 || coin_valid !== 1'b0)
          $display("FAIL done_busy_valid: got %b%b want 10",
                   busy, coin_valid);
        else passed++;
      end else if (coin_valid) begin
        seen++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_coin: got %b want none", coin);
          coin_ready = 1'b1;
        end else begin
          want = exp_q[0];
          checks++;
          if (coin !== want)
            $display("FAIL coin: got %b want %b", coin, want);
          else passed++;
          checks++;
          if (remaining !== exp_rem)
            $display("FAIL remaining: got %0d want %0d",
                     remaining, exp_rem);
          else passed++;
          if (waited >= stall) begin
            coin_ready = 1'b1;
            waited     = 0;
            void'(exp_q.pop_front());
            exp_rem = exp_rem - (want[2] ? 4'd5 :
                                 want[1] ? 4'd3 : 4'd1);
          end else begin
            coin_ready = 1'b0;
            waited++;
          end
        end
      end else begin
        coin_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || coin !== 3'b000)
          $display("FAIL plan_outputs: got busy=%b coin=%b want 1 000",
                   busy, coin);
        else passed++;
      end
    end
    if (!got_done) begin
      checks++;
      $display("FAIL done_timeout: got no done want done");
      exp_q.delete();
    end
    if (kind != 0) begin
      checks++;
      if (seen != 0)
        $display("FAIL no_coins: got %0d want 0", seen);
      else passed++;
    end
    @(negedge clock);
    checks++;
    if ({done, busy} !== 2'b00)
      $display("FAIL idle_after_done: got %b want 00", {done, busy});
    else passed++;
    checks++;
    if ({cough_up_more, exact_amount, not_enough_change} !==
        {kind == 1, kind == 2, kind == 3})
      $display("FAIL flags_held: got %b want %b",
               {cough_up_more, exact_amount, not_enough_change},
               {kind == 1, kind == 2, kind == 3});
    else passed++;
  endtask

  task automatic test_reset;
    reset_L = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({coin_valid, coin, remaining, busy, done, exact_amount,
         not_enough_change, cough_up_more, pent_cnt, tri_cnt,
         circ_cnt} !== 19'd0)
      $display("FAIL reset_outputs: got %b want 0",
               {coin_valid, coin, remaining, busy, done});
    else passed++;
    reset_L = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0)
      $display("FAIL busy_after_reset: got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_cough;
    run_txn(4'd7, 4'd3, 0, 1'b0);
  endtask

  task automatic test_exact;
    do_restock(2'd3, 2'd3, 2'd3);
    run_txn(4'd6, 4'd6, 0, 1'b0);
  endtask

  task automatic test_single_tri;
    do_restock(2'd1, 2'd1, 2'd3);
    run_txn(4'd6, 4'd9, 0, 1'b0);
  endtask

  task automatic test_stall_circ;
    do_restock(2'd0, 2'd0, 2'd3);
    run_txn(4'd6, 4'd9, 2, 1'b0);
  endtask

  task automatic test_not_enough;
    do_restock(2'd1, 2'd0, 2'd0);
    run_txn(4'd1, 4'd10, 0, 1'b0);
    do_restock(2'd2, 2'd0, 2'd0);
    run_txn(4'd1, 4'd11, 0, 1'b0);
  endtask

  task automatic test_non_greedy;
    do_restock(2'd1, 2'd2, 2'd0);
    run_txn(4'd0, 4'd6, 0, 1'b0);
  endtask

  task automatic test_start_priority;
    do_restock(2'd1, 2'd1, 2'd1);
    run_txn(4'd4, 4'd4, 0, 1'b1);
  endtask

  task automatic test_back_to_back;
    do_restock(2'd3, 2'd3, 2'd3);
    run_txn(4'd1, 4'd9, 0, 1'b0);
    run_txn(4'd0, 4'd4, 1, 1'b0);
    run_txn(4'd2, 4'd15, 0, 1'b0);
  endtask

  task automatic test_reset_mid_dispense;
    bit hit;
    do_restock(2'd0, 2'd0, 2'd3);
    @(negedge clock);
    start      = 1'b1;
    cost       = 4'd0;
    paid       = 4'd3;
    coin_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    hit   = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clock);
      if (coin_valid) hit = 1'b1;
    end
    checks++;
    if (!hit || coin !== 3'b001)
      $display("FAIL mid_dispense_coin: got %b want 001", coin);
    else passed++;
    reset_L = 1'b0;
    #1;
    checks++;
    if ({coin_valid, busy, done, coin, remaining} !== 10'd0)
      $display("FAIL async_reset: got %b want 0",
               {coin_valid, busy, done, coin, remaining});
    else passed++;
    @(negedge clock);
    checks++;
    if ({pent_cnt, tri_cnt, circ_cnt, coin_valid, busy} !== 8'd0)
      $display("FAIL reset_counts: got %b want 0",
               {pent_cnt, tri_cnt, circ_cnt, coin_valid, busy});
    else passed++;
    reset_L = 1'b1;
    mp = 2'd0;
    mt = 2'd0;
    mc = 2'd0;
    exp_q.delete();
    @(negedge clock);
  endtask

  initial begin
    reset_L      = 1'b0;
    restock      = 1'b0;
    restock_pent = 2'd0;
    restock_tri  = 2'd0;
    restock_circ = 2'd0;
    start        = 1'b0;
    cost         = 4'd0;
    paid         = 4'd0;
    coin_ready   = 1'b0;
    test_reset();
    test_cough();
    test_exact();
    test_single_tri();
    test_stall_circ();
    test_not_enough();
    test_non_greedy();
    test_start_priority();
    test_back_to_back();
    test_reset_mid_dispense();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
